// File: rtl/seq_accum_alu.sv
// seq_accum_alu
// Accumulator ALU with an 8-opcode datapath. The accumulator is ACC_W = 2*DATA_W bits wide.
// A start/busy/done handshake controls each operation. MUL is a multi-cycle shift-add
// multiplier. Every other opcode finishes in the cycle it is accepted.
//
// Optional feature: define SEQ_ACCUM_ALU_SAT_EN to saturate the result on ADD and SHL
// overflow. The ports are the same in both builds.
//
// Ports
//   clock    in   1       rising-edge clock
//   reset    in   1       asynchronous, active-high; clears all state
//   start_i  in   1       request; taken only while busy_o is 0
//   op_i     in   3       opcode, captured with start_i
//   a_i      in   DATA_W  operand A, captured with start_i
//   acc_o    out  ACC_W   accumulator register
//   busy_o   out  1       multiplier running; start_i is ignored
//   done_o   out  1       one-cycle pulse in the cycle after acc_o is written
//   ovf_o    out  1       overflow flag, valid with done_o, 0 otherwise
module seq_accum_alu #(
  parameter int unsigned DATA_W = 4
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start_i,
  input  logic [2:0]            op_i,
  input  logic [DATA_W-1:0]     a_i,
  output logic [2*DATA_W-1:0]   acc_o,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  ovf_o
);

  localparam int unsigned ACC_W = 2 * DATA_W;
  localparam int unsigned CNT_W = $clog2(DATA_W) + 1;

  typedef enum logic {StIdle, StMul} state_e;

  state_e             state_q, state_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic               done_q, done_d;
  logic               ovf_q, ovf_d;
  logic [ACC_W-1:0]   mcand_q, mcand_d;
  logic [DATA_W-1:0]  mplier_q, mplier_d;
  logic [ACC_W-1:0]   prod_q, prod_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  logic [DATA_W-1:0]  lo;
  logic [ACC_W-1:0]   a_ext;
  int unsigned        sh;
  logic [ACC_W:0]     add_sum;
  logic [ACC_W-1:0]   shl_res;
  logic               shl_ovf;
  logic [ACC_W-1:0]   prod_next;

  assign lo    = acc_q[DATA_W-1:0];
  assign a_ext = ACC_W'(a_i);
  assign sh    = 32'(a_i);

  always_comb begin
    add_sum = {1'b0, acc_q} + {1'b0, a_ext};
    shl_res = (sh >= ACC_W) ? '0 : (acc_q << sh);
    // Overflow when any 1 bit leaves the top of the accumulator.
    if (sh == 0) begin
      shl_ovf = 1'b0;
    end else if (sh >= ACC_W) begin
      shl_ovf = |acc_q;
    end else begin
      shl_ovf = |(acc_q >> (ACC_W - sh));
    end
    prod_next = mplier_q[0] ? (prod_q + mcand_q) : prod_q;
  end

  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    done_d   = 1'b0;
    ovf_d    = 1'b0;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    prod_d   = prod_q;
    cnt_d    = cnt_q;

    unique case (state_q)
      StIdle: begin
        if (start_i) begin
          // MUL sets done_d when it finishes. All other opcodes set it here.
          done_d = (op_i != 3'b000);
          unique case (op_i)
            3'b000: begin
              mcand_d  = a_ext;
              mplier_d = lo;
              prod_d   = '0;
              cnt_d    = '0;
              state_d  = StMul;
            end
            3'b001: acc_d = (sh >= ACC_W) ? '0 : (acc_q >> sh);
            3'b010: begin
              ovf_d = shl_ovf;
`ifdef SEQ_ACCUM_ALU_SAT_EN
              acc_d = shl_ovf ? '1 : shl_res;
`else
              acc_d = shl_res;
`endif
            end
            3'b011: acc_d = ACC_W'((|a_i) | (|lo));
            3'b100: acc_d = {a_i | lo, a_i ^ lo};
            3'b101: begin
              ovf_d = add_sum[ACC_W];
`ifdef SEQ_ACCUM_ALU_SAT_EN
              acc_d = add_sum[ACC_W] ? '1 : add_sum[ACC_W-1:0];
`else
              acc_d = add_sum[ACC_W-1:0];
`endif
            end
            3'b110: acc_d = a_ext + ACC_W'(1);
            3'b111: acc_d = '0;
          endcase
        end
      end
      StMul: begin
        prod_d   = prod_next;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + CNT_W'(1);
        // The last step writes its result straight into the accumulator.
        if (cnt_q == CNT_W'(DATA_W - 1)) begin
          acc_d   = prod_next;
          done_d  = 1'b1;
          state_d = StIdle;
        end
      end
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= StIdle;
      acc_q    <= '0;
      done_q   <= 1'b0;
      ovf_q    <= 1'b0;
      mcand_q  <= '0;
      mplier_q <= '0;
      prod_q   <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      done_q   <= done_d;
      ovf_q    <= ovf_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      prod_q   <= prod_d;
      cnt_q    <= cnt_d;
    end
  end

  assign acc_o  = acc_q;
  assign busy_o = (state_q == StMul);
  assign done_o = done_q;
  assign ovf_o  = ovf_q;

endmodule

// File: tb/tb_seq_accum_alu.sv
// Testbench for seq_accum_alu. Random and directed stimulus drives the DUT, and a
// behavioural reference model predicts each result. Every accepted request pushes its
// expected result into a scoreboard queue. A monitor pops one entry on each done_o pulse
// and compares it with the DUT outputs.
module tb_seq_accum_alu;

  localparam int DATA_W = 4;
  localparam int ACC_W  = 2 * DATA_W;

  typedef struct {
    logic [ACC_W-1:0] acc;
    logic             ovf;
    logic [2:0]       op;
  } exp_t;

  logic              clock;
  logic              reset;
  logic              start_i;
  logic [2:0]        op_i;
  logic [DATA_W-1:0] a_i;
  logic [ACC_W-1:0]  acc_o;
  logic              busy_o;
  logic              done_o;
  logic              ovf_o;

  exp_t   sb_q[$];
  longint model_acc;
  int     n_vec;
  int     n_fail;

  seq_accum_alu #(.DATA_W(DATA_W)) dut (
    .clock   (clock),
    .reset   (reset),
    .start_i (start_i),
    .op_i    (op_i),
    .a_i     (a_i),
    .acc_o   (acc_o),
    .busy_o  (busy_o),
    .done_o  (done_o),
    .ovf_o   (ovf_o)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, got, exp, $time);
    end
  endtask

  // Reference model: the result of each opcode, computed with plain integer arithmetic.
  function automatic void ref_op(input int op, input longint a, input longint acc,
                                 output longint res, output bit ovf);
    longint lo   = acc % (longint'(1) << DATA_W);
    longint modv = longint'(1) << ACC_W;
    longint full;
    ovf = 1'b0;
    case (op)
      0: res = a * lo;
      1: res = (a >= ACC_W) ? 0 : (acc >> a);
      2: begin
        full = acc << a;
        res  = full % modv;
        ovf  = (full >= modv);
`ifdef SEQ_ACCUM_ALU_SAT_EN
        if (ovf) res = modv - 1;
`endif
      end
      3: res = (a != 0 || lo != 0) ? 1 : 0;
      4: res = ((a | lo) << DATA_W) | (a ^ lo);
      5: begin
        full = acc + a;
        res  = full % modv;
        ovf  = (full >= modv);
`ifdef SEQ_ACCUM_ALU_SAT_EN
        if (ovf) res = modv - 1;
`endif
      end
      6: res = a + 1;
      default: res = 0;
    endcase
  endfunction

  // Call about 1 time unit after a rising edge. The request is captured on the next edge.
  task automatic issue(input int op, input int a);
    longint res;
    bit     ov;
    exp_t   e;
    start_i = 1'b1;
    op_i    = op[2:0];
    a_i     = a[DATA_W-1:0];
    ref_op(op, longint'(a), model_acc, res, ov);
    e.acc = res[ACC_W-1:0];
    e.ovf = ov;
    e.op  = op[2:0];
    @(posedge clock);
    sb_q.push_back(e);
    #1;
    if (op == 0) begin
      // Throughout the multiply, keep requesting random operations. None of them may be taken.
      repeat (DATA_W) begin
        check("busy_during_mul", 64'(busy_o), 64'd1);
        check("acc_hold_mul", 64'(acc_o), 64'(model_acc[ACC_W-1:0]));
        start_i = 1'b1;
        op_i    = 3'($urandom);
        a_i     = DATA_W'($urandom);
        @(posedge clock);
        #1;
      end
      check("busy_clear_after_mul", 64'(busy_o), 64'd0);
    end
    start_i   = 1'b0;
    model_acc = res;
  endtask

  task automatic idle(input int n);
    start_i = 1'b0;
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  // Assert reset between clock edges. The outputs must clear without waiting for an edge.
  task automatic reset_now();
    #2;
    reset = 1'b1;
    #1;
    check("async_reset_acc", 64'(acc_o), 64'd0);
    check("async_reset_busy", 64'(busy_o), 64'd0);
    check("async_reset_done", 64'(done_o), 64'd0);
    sb_q.delete();
    model_acc = 0;
    @(negedge clock);
    reset = 1'b0;
    @(posedge clock);
    #1;
  endtask

  // Monitor: each done_o pulse must match exactly one scoreboard entry.
  initial begin
    exp_t e;
    forever begin
      @(negedge clock);
      if (!reset) begin
        if (done_o) begin
          if (sb_q.size() == 0) begin
            check("unexpected_done", 64'(done_o), 64'd0);
          end else begin
            e = sb_q.pop_front();
            check($sformatf("acc_op%0d", e.op), 64'(acc_o), 64'(e.acc));
            check($sformatf("ovf_op%0d", e.op), 64'(ovf_o), 64'(e.ovf));
          end
        end else begin
          check("ovf_without_done", 64'(ovf_o), 64'd0);
        end
      end
    end
  end

  initial begin
    n_vec     = 0;
    n_fail    = 0;
    model_acc = 0;
    reset     = 1'b1;
    start_i   = 1'b0;
    op_i      = 3'd0;
    a_i       = '0;
    #3;
    check("reset_acc", 64'(acc_o), 64'd0);
    check("reset_busy", 64'(busy_o), 64'd0);
    check("reset_done", 64'(done_o), 64'd0);
    check("reset_ovf", 64'(ovf_o), 64'd0);
    @(negedge clock);
    reset = 1'b0;
    @(posedge clock);
    #1;

    // CLR, then INC 5 -> 0x06. Next, MUL 7 -> 0x2A, with requests ignored while busy.
    issue(7, 0);
    issue(6, 5);
    idle(2);
    check("inc_then_idle_done_low", 64'(done_o), 64'd0);
    issue(0, 7);
    idle(2);
    check("mul_result_0x2a", 64'(acc_o), 64'h2A);

    // Reset between clock edges while the accumulator holds a nonzero value.
    reset_now();

    // Build acc = 0xFE, then ADD 3 overflows.
    issue(6, 14);
    issue(0, 15);
    issue(5, 13);
    issue(5, 15);
    issue(5, 1);
    issue(5, 3);

    // acc = 0x0A, then LOGIC 6, SHL 2 and SHR 9. These run back to back.
    issue(7, 0);
    issue(6, 9);
    issue(4, 6);
    issue(2, 2);
    issue(1, 9);
    idle(2);

    // Reset two cycles into a MUL: no done pulse may follow.
    issue(6, 6);
    idle(1);
    start_i = 1'b1;
    op_i    = 3'd0;
    a_i     = DATA_W'(5);
    @(posedge clock);
    #1;
    start_i = 1'b0;
    idle(2);
    check("busy_before_mid_reset", 64'(busy_o), 64'd1);
    sb_q.delete();
    reset_now();
    idle(DATA_W + 3);

    // Random traffic, mostly back to back with occasional idle gaps.
    for (int i = 0; i < 300; i++) begin
      issue(int'($urandom_range(0, 7)), int'($urandom_range(0, (1 << DATA_W) - 1)));
      if ($urandom_range(0, 3) == 0) idle(1);
    end

    idle(DATA_W + 3);
    check("scoreboard_drained", 64'(sb_q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
